// File: rtl/egress_pkg.sv
// Shared types, defaults and sizing helper for the egress serializer.
// Pure package: no latency, no backpressure.
package egress_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT, GAP} egress_state_t;

  localparam int WORD_W_DEF     = 32;
  localparam int MSB_FIRST_DEF  = 0;
  localparam int GAP_CYCLES_DEF = 1;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/egress_shifter.sv
// Word holding register and bit index; bit_o is the bit to be shown after this edge.
// Latency: load/advance take effect on the next edge; backpressure: holds when neither is set.
module egress_shifter
  import egress_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int MSB_FIRST = MSB_FIRST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [WORD_W-1:0] data_in,
  output logic              bit_o,
  output logic              at_last_bit,
  output logic              at_penult_bit
);

  localparam int CW = cnt_w(WORD_W);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORD_W - 1);

  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] src;
  logic [CW-1:0]     bitcnt;
  logic [CW-1:0]     nxt_idx;
  logic [CW-1:0]     sel_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (load) begin
      shreg  <= data_in;
      bitcnt <= '0;
    end else if (advance) begin
      bitcnt <= bitcnt + 1'b1;
    end
  end

  // Look ahead so the top can register the bit in the same edge that loads/advances.
  always_comb begin
    src     = load ? data_in : shreg;
    nxt_idx = load ? '0 : bitcnt + 1'b1;
    sel_idx = (MSB_FIRST != 0) ? LAST_IDX - nxt_idx : nxt_idx;
    bit_o   = src[sel_idx];
  end

  assign at_last_bit   = (bitcnt == LAST_IDX);
  assign at_penult_bit = (bitcnt == LAST_IDX - 1'b1);

endmodule

// File: rtl/egress_serializer.sv
// Drains a FWFT FIFO and sends words serially with active-low frame/valid, underrun padding and inter-frame gap.
// Latency: pop in C gives bit 0 in C+1; backpressure: stall in C holds the bit and drops valid in C+1.
module egress_serializer
  import egress_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int MSB_FIRST  = MSB_FIRST_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] datain,
  input  logic              lastin,
  input  logic              empty,
  input  logic              stall,
  output logic              pop,
  output logic              dataout,
  output logic              frameo_n,
  output logic              valido_n,
  output logic              busy,
  output logic              underrun
);

  localparam int GW = cnt_w(GAP_CYCLES);

  egress_state_t   state, state_nxt;
  logic            take;
  logic            load;
  logic            advance;
  logic            last_q;
  logic            bit_nxt;
  logic            at_last_bit;
  logic            at_penult_bit;
  logic [GW-1:0]   gap_cnt;

  egress_shifter #(
    .WORD_W    (WORD_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .advance       (advance),
    .data_in       (datain),
    .bit_o         (bit_nxt),
    .at_last_bit   (at_last_bit),
    .at_penult_bit (at_penult_bit)
  );

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE, WAIT: begin
        if (!empty && !stall) begin
          take      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!stall) begin
          if (!at_last_bit) begin
            advance = 1'b1;
          end else if (last_q) begin
            state_nxt = GAP;
          end else if (!empty) begin
            take = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pop  = take & ~reset;
  assign load = pop;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      last_q  <= 1'b0;
      gap_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load) last_q <= lastin;
      if (state != GAP && state_nxt == GAP) begin
        gap_cnt <= GW'(GAP_CYCLES - 1);
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  // frameo_n goes high together with the final bit of a frame-ending word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataout  <= 1'b0;
      frameo_n <= 1'b1;
      valido_n <= 1'b1;
      underrun <= 1'b0;
    end else begin
      underrun <= (state == SHIFT) && (state_nxt == WAIT);
      if (load || advance) begin
        dataout  <= bit_nxt;
        valido_n <= 1'b0;
        frameo_n <= advance && at_penult_bit && last_q;
      end else begin
        valido_n <= 1'b1;
        case (state_nxt)
          IDLE, GAP: begin
            frameo_n <= 1'b1;
            dataout  <= 1'b0;
          end
          WAIT:    frameo_n <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_egress_serializer.sv
// Scoreboard bench: two serializer instances (LSB-first/gap 1 and MSB-first/gap 3) fed from FIFO models.
// Expected bit streams are built from popped words; per-lane monitors check protocol every cycle.
module tb_egress_serializer;

  localparam int W     = 32;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic reset;
  logic fin = 1'b0;

  logic [1:0][W-1:0] datain_v;
  logic [1:0] lastin_v, empty_v, stall_v, hold_v, pop_v;
  logic [1:0] dataout_v, frameo_n_v, valido_n_v, busy_v, underrun_v, drained_v;

  logic [W:0] fmem [2][DEPTH];
  logic [9:0] wp [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int ln, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d t=%0t: got %0h, expected %0h", nm, ln, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int MSB     = (g == 1) ? 1 : 0;
    localparam int LGAP    = (g == 1) ? 3 : 1;
    localparam int PH_IDLE = 0;
    localparam int PH_XFER = 1;
    localparam int PH_WAIT = 2;
    localparam int PH_GAP  = 3;

    logic [9:0] rp = '0;

    egress_serializer #(
      .WORD_W     (W),
      .MSB_FIRST  (MSB),
      .GAP_CYCLES (LGAP)
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .datain   (datain_v[g]),
      .lastin   (lastin_v[g]),
      .empty    (empty_v[g]),
      .stall    (stall_v[g]),
      .pop      (pop_v[g]),
      .dataout  (dataout_v[g]),
      .frameo_n (frameo_n_v[g]),
      .valido_n (valido_n_v[g]),
      .busy     (busy_v[g]),
      .underrun (underrun_v[g])
    );

    assign empty_v[g]   = (rp == wp[g]) || hold_v[g];
    assign datain_v[g]  = fmem[g][rp][W:1];
    assign lastin_v[g]  = fmem[g][rp][0];
    assign drained_v[g] = (rp == wp[g]) && !busy_v[g];

    always @(posedge clk) if (pop_v[g]) rp <= rp + 10'd1;

    // Expected stream entries: {word_end, frame_end, bit}.
    logic [2:0] sq[$];
    int ph       = PH_IDLE;
    int gap_left = 0;
    bit exp_ur = 0, prev_stall = 0, cur_we = 0, cur_fe = 0, cur_bit = 0, exp_pop = 0;

    always begin : mon
      logic [2:0]   e;
      logic [W-1:0] dw;
      logic         lw;
      int           k;
      @(negedge clk);
      #2;
      if (reset) begin
        chk("rst_frameo_n", g, frameo_n_v[g], 1);
        chk("rst_valido_n", g, valido_n_v[g], 1);
        chk("rst_dataout", g, dataout_v[g], 0);
        chk("rst_busy", g, busy_v[g], 0);
        chk("rst_pop", g, pop_v[g], 0);
        chk("rst_underrun", g, underrun_v[g], 0);
        ph = PH_IDLE;
        sq.delete();
        exp_ur = 0;
        prev_stall = 0;
      end else begin
        chk("underrun", g, underrun_v[g], exp_ur);
        exp_ur = 0;
        chk("busy", g, busy_v[g], (ph != PH_IDLE));
        exp_pop = 0;
        case (ph)
          PH_IDLE, PH_GAP: begin
            chk("idle_frameo_n", g, frameo_n_v[g], 1);
            chk("idle_valido_n", g, valido_n_v[g], 1);
            exp_pop = (ph == PH_IDLE) && !empty_v[g] && !stall_v[g];
          end
          PH_WAIT: begin
            chk("wait_frameo_n", g, frameo_n_v[g], 0);
            chk("wait_valido_n", g, valido_n_v[g], 1);
            chk("wait_dataout", g, dataout_v[g], cur_bit);
            exp_pop = !empty_v[g] && !stall_v[g];
          end
          default: begin
            chk("xfer_valido_n", g, valido_n_v[g], prev_stall);
            if (!valido_n_v[g]) begin
              if (sq.size() == 0) begin
                chk("stream_underflow", g, 1, 0);
              end else begin
                e = sq.pop_front();
                cur_we = e[2];
                cur_fe = e[1];
                cur_bit = e[0];
                chk("dataout", g, dataout_v[g], cur_bit);
              end
            end else begin
              chk("stall_dataout", g, dataout_v[g], cur_bit);
            end
            chk("xfer_frameo_n", g, frameo_n_v[g], cur_fe);
            exp_pop = cur_we && !cur_fe && !stall_v[g] && !empty_v[g];
          end
        endcase
        chk("pop", g, pop_v[g], exp_pop);

        case (ph)
          PH_IDLE, PH_WAIT: if (exp_pop) ph = PH_XFER;
          PH_GAP: begin
            gap_left--;
            if (gap_left == 0) ph = PH_IDLE;
          end
          default: begin
            if (!stall_v[g] && cur_we) begin
              if (cur_fe) begin
                ph = PH_GAP;
                gap_left = LGAP;
              end else if (empty_v[g]) begin
                ph = PH_WAIT;
                exp_ur = 1;
              end
            end
          end
        endcase

        if (exp_pop) begin
          dw = fmem[g][rp][W:1];
          lw = fmem[g][rp][0];
          for (int i = 0; i < W; i++) begin
            k = (MSB != 0) ? (W - 1 - i) : i;
            sq.push_back({(i == W - 1) ? 1'b1 : 1'b0, (i == W - 1 && lw) ? 1'b1 : 1'b0, dw[k]});
          end
        end
        prev_stall = stall_v[g];
      end
    end

    always @(posedge fin) chk("stream_left", g, sq.size(), 0);
  end

  task automatic push(input int g, input logic [W-1:0] d, input logic l);
    fmem[g][wp[g]] = {d, l};
    wp[g] = wp[g] + 10'd1;
  endtask

  task automatic wait_idle(input int g);
    bit ok;
    ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      ok = drained_v[g];
    end
    chk("drain_timeout", g, ok, 1);
  endtask

  initial begin
    reset   = 1'b1;
    stall_v = '0;
    hold_v  = '0;
    wp[0]   = '0;
    wp[1]   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Single one-word frame.
    @(negedge clk);
    push(0, 32'h0000_0005, 1'b1);
    wait_idle(0);

    // Two preloaded words chained into one frame.
    hold_v[0] = 1'b1;
    push(0, 32'hFFFF_0000, 1'b0);
    push(0, 32'h1234_5678, 1'b1);
    @(negedge clk);
    hold_v[0] = 1'b0;
    wait_idle(0);

    // Stall for three cycles while bit 10 is shown.
    push(0, $urandom, 1'b1);
    repeat (11) @(negedge clk);
    stall_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    stall_v[0] = 1'b0;
    wait_idle(0);

    // Underrun: five cycles of padding before the second word arrives.
    push(0, 32'hA5A5_0F0F, 1'b0);
    repeat (37) @(negedge clk);
    push(0, 32'h0000_FFFF, 1'b1);
    wait_idle(0);

    // MSB-first lane with a three-cycle gap, next frame preloaded.
    hold_v[1] = 1'b1;
    push(1, 32'h8000_0001, 1'b1);
    push(1, 32'h0F0F_3C3C, 1'b1);
    @(negedge clk);
    hold_v[1] = 1'b0;
    wait_idle(1);

    // Reset while bit 17 is shown; the preloaded frame must start afresh.
    hold_v[0] = 1'b1;
    push(0, $urandom, 1'b1);
    push(0, 32'hC001_D00D, 1'b1);
    @(negedge clk);
    hold_v[0] = 1'b0;
    repeat (18) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_idle(0);

    // Random traffic, stalls and FIFO starvation on both lanes.
    begin : rnd
      int cnt [2];
      cnt[0] = 0;
      cnt[1] = 0;
      for (int c = 0; c < 8000 && (cnt[0] < 40 || cnt[1] < 40); c++) begin
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
          if (cnt[g] < 40 && $urandom_range(0, 2) == 0) begin
            push(g, $urandom, (cnt[g] == 39) || ($urandom_range(0, 3) == 0));
            cnt[g]++;
          end
          stall_v[g] = ($urandom_range(0, 4) == 0);
          hold_v[g]  = ($urandom_range(0, 5) == 0);
        end
      end
      stall_v = '0;
      hold_v  = '0;
      wait_idle(0);
      wait_idle(1);
    end

    fin = 1'b1;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
